// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard emulator: queues scan-code bytes and sends each one as an
// 11-bit frame (start, 8 data LSB first, odd parity, stop) on ps2_clk/ps2_data.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | lines high, pop the queue head into the frame shifter when available
// LOAD   | one cycle, start bit presented on ps2_data
// HIGH   | ps2_clk high for CLK_DIV cycles, current bit held on ps2_data
// LOW    | ps2_clk low for CLK_DIV cycles, receiver samples on the falling edge
// GAP    | both lines high for GAP_CYC cycles between frames
module ps2_kbd_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYC    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       drop,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic [7:0] sent_count
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int TMR_MAX = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int TW      = $clog2(TMR_MAX + 1);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] DIV_LD  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic [3:0]    bit_cnt, bit_cnt_nxt;
    logic [10:0]   shreg, shreg_nxt;
    logic [7:0]    sent_nxt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          push, pop;
    logic [7:0]    head;

    assign push = wr_en && !full;
    assign head = mem[rd_ptr];

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        sent_nxt    = sent_count;
        pop         = 1'b0;

        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    shreg_nxt   = {1'b1, ~^head, head, 1'b0};
                    bit_cnt_nxt = 4'd0;
                    state_nxt   = S_LOAD;
                end
            end
            S_LOAD: begin
                bit_cnt_nxt = 4'd0;
                tmr_nxt     = DIV_LD;
                state_nxt   = S_HIGH;
            end
            S_HIGH: begin
                if (tmr == '0) begin
                    tmr_nxt   = DIV_LD;
                    state_nxt = S_LOW;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_LOW: begin
                if (tmr == '0) begin
                    if (bit_cnt == 4'd10) begin
                        sent_nxt  = sent_count + 8'd1;
                        tmr_nxt   = GAP_LD;
                        state_nxt = S_GAP;
                    end else begin
                        shreg_nxt   = shreg >> 1;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        tmr_nxt     = DIV_LD;
                        state_nxt   = S_HIGH;
                    end
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_GAP: begin
                if (tmr == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state      <= S_IDLE;
            tmr        <= '0;
            bit_cnt    <= 4'd0;
            shreg      <= '1;
            sent_count <= 8'd0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            drop       <= 1'b0;
            busy       <= 1'b0;
            ps2_clk    <= 1'b1;
            ps2_data   <= 1'b1;
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            sent_count <= sent_nxt;
            count      <= count_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            full       <= (count_nxt == DEPTH_C);
            drop       <= wr_en && full;
            busy       <= (state_nxt != S_IDLE) || (count_nxt != '0);
            ps2_clk    <= (state_nxt != S_LOW);
            ps2_data   <= (state_nxt == S_LOAD || state_nxt == S_HIGH || state_nxt == S_LOW)
                          ? shreg_nxt[0] : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a line monitor decodes frames from ps2_clk falls and the
// scenarios compare them against frames built from the byte values and odd-parity rule.
module tb_ps2_kbd_tx;

    localparam int CLK_DIV    = 4;
    localparam int GAP_CYC    = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int PERIOD     = 2 + 22 * CLK_DIV + GAP_CYC;

    logic       clk = 1'b0;
    logic       clrn = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, drop, busy, ps2_clk, ps2_data;
    logic [7:0] sent_count;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int exp_sent   = 0;
    int cyc        = 0;

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .clrn(clrn), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .drop(drop), .busy(busy),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .sent_count(sent_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: records frames, frame timing, data changes while clock low, setup time.
    logic        prev_clk = 1'b1, prev_data = 1'b1;
    int          bit_idx = 0, cur_start = 0, last_chg = 0;
    logic [10:0] cur_bits = '0;
    logic [10:0] frames[$];
    int          fstart[$], fend[$];
    int          total_falls = 0, glitch_cnt = 0, min_setup = 1000;

    always @(negedge clk) begin
        if (!clrn) begin
            bit_idx   = 0;
            prev_clk  = 1'b1;
            prev_data = 1'b1;
        end else begin
            if (ps2_data !== prev_data) begin
                if (ps2_clk === 1'b0) glitch_cnt++;
                last_chg = cyc;
            end
            if (prev_clk === 1'b1 && ps2_clk === 1'b0) begin
                total_falls++;
                if (cyc - last_chg < min_setup) min_setup = cyc - last_chg;
                cur_bits[bit_idx] = ps2_data;
                if (bit_idx == 0) cur_start = cyc;
                if (bit_idx == 10) begin
                    frames.push_back(cur_bits);
                    fstart.push_back(cur_start);
                    fend.push_back(cyc);
                    bit_idx = 0;
                end else begin
                    bit_idx++;
                end
            end
            prev_clk  = ps2_clk;
            prev_data = ps2_data;
        end
    end

    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic clear_mon();
        frames.delete();
        fstart.delete();
        fend.delete();
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int k = 0;
        while (frames.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (frames.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        #2 clrn = 1'b0;
        repeat (3) @(negedge clk);
        assert_cnt++; if (ps2_clk !== 1'b1) begin fail_cnt++; $display("FAIL reset_ps2_clk: got %b expected 1", ps2_clk); end
        assert_cnt++; if (ps2_data !== 1'b1) begin fail_cnt++; $display("FAIL reset_ps2_data: got %b expected 1", ps2_data); end
        assert_cnt++; if (full !== 1'b0) begin fail_cnt++; $display("FAIL reset_full: got %b expected 0", full); end
        assert_cnt++; if (drop !== 1'b0) begin fail_cnt++; $display("FAIL reset_drop: got %b expected 0", drop); end
        assert_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
        assert_cnt++; if (sent_count !== 8'd0) begin fail_cnt++; $display("FAIL reset_sent: got %0d expected 0", sent_count); end
        clrn = 1'b1;
        exp_sent = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_1c();
        bit ok;
        clear_mon();
        push_byte(8'h1C);
        wait_frames(1, 400, ok);
        assert_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL single_timeout: got %0d frames expected 1", frames.size()); end
        if (ok) begin
            exp_sent++;
            assert_cnt++; if (frames[0] !== 11'b10000111000) begin fail_cnt++; $display("FAIL single_bits: got %b expected 10000111000", frames[0]); end
            assert_cnt++; if (fend[0] - fstart[0] !== 20 * CLK_DIV) begin fail_cnt++; $display("FAIL single_span: got %0d expected %0d", fend[0] - fstart[0], 20 * CLK_DIV); end
        end
        wait_idle(200, ok);
        assert_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL single_idle: busy got %b expected 0", busy); end
        assert_cnt++; if (sent_count !== 8'(exp_sent)) begin fail_cnt++; $display("FAIL single_sent: got %0d expected %0d", sent_count, exp_sent); end
        assert_cnt++; if ({ps2_clk, ps2_data} !== 2'b11) begin fail_cnt++; $display("FAIL single_lines: got %b expected 11", {ps2_clk, ps2_data}); end
    endtask

    task automatic test_make_break();
        bit ok;
        logic [7:0] seq [3];
        seq[0] = 8'h1C; seq[1] = 8'hF0; seq[2] = 8'h1C;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = seq[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_frames(3, 600, ok);
        assert_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL mb_timeout: got %0d frames expected 3", frames.size()); end
        if (ok) begin
            exp_sent += 3;
            for (int i = 0; i < 3; i++) begin
                assert_cnt++; if (frames[i] !== model_frame(seq[i])) begin fail_cnt++; $display("FAIL mb_frame%0d: got %b expected %b", i, frames[i], model_frame(seq[i])); end
            end
            for (int i = 1; i < 3; i++) begin
                assert_cnt++; if (fstart[i] - fstart[i-1] !== PERIOD) begin fail_cnt++; $display("FAIL mb_period%0d: got %0d expected %0d", i, fstart[i] - fstart[i-1], PERIOD); end
            end
        end
        wait_idle(300, ok);
        assert_cnt++; if (sent_count !== 8'(exp_sent)) begin fail_cnt++; $display("FAIL mb_sent: got %0d expected %0d", sent_count, exp_sent); end
    endtask

    task automatic test_parity_edges();
        bit ok;
        clear_mon();
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_frames(2, 600, ok);
        assert_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL par_timeout: got %0d frames expected 2", frames.size()); end
        if (ok) begin
            exp_sent += 2;
            assert_cnt++; if (frames[0][9] !== 1'b1) begin fail_cnt++; $display("FAIL par_00: got %b expected 1", frames[0][9]); end
            assert_cnt++; if (frames[1][9] !== 1'b1) begin fail_cnt++; $display("FAIL par_ff: got %b expected 1", frames[1][9]); end
            assert_cnt++; if ({frames[1][10], frames[0][10]} !== 2'b11) begin fail_cnt++; $display("FAIL par_stop: got %b expected 11", {frames[1][10], frames[0][10]}); end
            assert_cnt++; if ({frames[1][8:1], frames[0][8:1]} !== 16'hFF00) begin fail_cnt++; $display("FAIL par_data: got %h expected ff00", {frames[1][8:1], frames[0][8:1]}); end
        end
        wait_idle(300, ok);
    endtask

    task automatic test_random();
        bit ok;
        logic [7:0] exp_q[$];
        int pushed = 0;
        clear_mon();
        while (pushed < 24) begin
            @(negedge clk);
            if (!full && $urandom_range(0, 1) == 1) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                exp_q.push_back(wr_data);
                pushed++;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(negedge clk);
        wr_en = 1'b0;
        wait_frames(24, 24 * PERIOD + 500, ok);
        assert_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL rnd_timeout: got %0d frames expected 24", frames.size()); end
        if (ok) begin
            exp_sent += 24;
            for (int i = 0; i < 24; i++) begin
                assert_cnt++; if (frames[i] !== model_frame(exp_q[i])) begin fail_cnt++; $display("FAIL rnd_frame%0d: got %b expected %b", i, frames[i], model_frame(exp_q[i])); end
            end
        end
        wait_idle(300, ok);
        assert_cnt++; if (sent_count !== 8'(exp_sent)) begin fail_cnt++; $display("FAIL rnd_sent: got %0d expected %0d", sent_count, exp_sent); end
        assert_cnt++; if (glitch_cnt !== 0) begin fail_cnt++; $display("FAIL data_while_clk_low: got %0d changes expected 0", glitch_cnt); end
        assert_cnt++; if (min_setup < CLK_DIV) begin fail_cnt++; $display("FAIL data_setup: got %0d cycles expected >= %0d", min_setup, CLK_DIV); end
    endtask

    task automatic test_fill_in_gap();
        bit ok;
        logic [7:0] b [9];
        clear_mon();
        for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
        push_byte(8'($urandom));
        wait_frames(1, 400, ok);
        assert_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL fill_first_timeout: got %0d frames expected 1", frames.size()); end
        repeat (CLK_DIV + 1) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 7) begin
                assert_cnt++; if (full !== 1'b0) begin fail_cnt++; $display("FAIL fill_full7: got %b expected 0", full); end
            end
            if (i == 8) begin
                assert_cnt++; if (full !== 1'b1) begin fail_cnt++; $display("FAIL fill_full8: got %b expected 1", full); end
                assert_cnt++; if (drop !== 1'b0) begin fail_cnt++; $display("FAIL fill_drop8: got %b expected 0", drop); end
            end
            wr_en   = 1'b1;
            wr_data = b[i];
        end
        @(negedge clk);
        wr_en = 1'b0;
        assert_cnt++; if (drop !== 1'b1) begin fail_cnt++; $display("FAIL fill_drop9: got %b expected 1", drop); end
        @(negedge clk);
        assert_cnt++; if (drop !== 1'b0) begin fail_cnt++; $display("FAIL fill_drop_pulse: got %b expected 0", drop); end
        wait_frames(9, 9 * PERIOD + 500, ok);
        assert_cnt++; if (ok !== 1'b1) begin fail_cnt++; $display("FAIL fill_timeout: got %0d frames expected 9", frames.size()); end
        if (ok) begin
            exp_sent += 9;
            for (int i = 0; i < 8; i++) begin
                assert_cnt++; if (frames[i+1] !== model_frame(b[i])) begin fail_cnt++; $display("FAIL fill_frame%0d: got %b expected %b", i, frames[i+1], model_frame(b[i])); end
            end
        end
        wait_idle(300, ok);
        assert_cnt++; if (frames.size() !== 9) begin fail_cnt++; $display("FAIL fill_extra: got %0d frames expected 9", frames.size()); end
        assert_cnt++; if (sent_count !== 8'(exp_sent)) begin fail_cnt++; $display("FAIL fill_sent: got %0d expected %0d", sent_count, exp_sent); end
    endtask

    task automatic test_reset_mid_frame();
        int k = 0;
        int falls_before;
        clear_mon();
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = 8'($urandom) & 8'hEF;
        @(negedge clk);
        wr_data = 8'($urandom);
        @(negedge clk);
        wr_en = 1'b0;
        while (bit_idx != 5 && k < 400) begin
            @(negedge clk);
            k++;
        end
        assert_cnt++; if (bit_idx !== 5) begin fail_cnt++; $display("FAIL mid_timeout: got bit %0d expected 5", bit_idx); end
        repeat (CLK_DIV + 1) @(negedge clk);
        assert_cnt++; if (ps2_data !== 1'b0) begin fail_cnt++; $display("FAIL mid_bit4: got %b expected 0", ps2_data); end
        falls_before = total_falls;
        clrn = 1'b0;
        #1;
        assert_cnt++; if ({ps2_clk, ps2_data} !== 2'b11) begin fail_cnt++; $display("FAIL mid_lines: got %b expected 11", {ps2_clk, ps2_data}); end
        assert_cnt++; if (sent_count !== 8'd0) begin fail_cnt++; $display("FAIL mid_sent: got %0d expected 0", sent_count); end
        assert_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL mid_busy: got %b expected 0", busy); end
        @(negedge clk);
        clrn = 1'b1;
        exp_sent = 0;
        repeat (300) @(negedge clk);
        assert_cnt++; if (total_falls !== falls_before) begin fail_cnt++; $display("FAIL mid_edges: got %0d falls expected %0d", total_falls, falls_before); end
        assert_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("FAIL mid_queue: busy got %b expected 0", busy); end
        assert_cnt++; if (sent_count !== 8'd0) begin fail_cnt++; $display("FAIL mid_sent_after: got %0d expected 0", sent_count); end
    endtask

    task automatic test_wrap_256();
        logic [7:0] exp_q[$];
        int pushed = 0, guard = 0, busy_low = 0, k = 0, bad = 0, bad_period = 0;
        logic [7:0] prev_sent = 8'd0;
        bit wrapped = 0;
        clear_mon();
        while (frames.size() < 256 && guard < 30000) begin
            @(negedge clk);
            guard++;
            if (pushed > 0 && busy !== 1'b1) busy_low++;
            if (prev_sent == 8'd255 && sent_count == 8'd0) wrapped = 1;
            prev_sent = sent_count;
            if (pushed < 256 && !full) begin
                wr_en   = 1'b1;
                wr_data = 8'($urandom);
                exp_q.push_back(wr_data);
                pushed++;
            end else begin
                wr_en = 1'b0;
            end
        end
        wr_en = 1'b0;
        assert_cnt++; if (frames.size() !== 256) begin fail_cnt++; $display("FAIL wrap_timeout: got %0d frames expected 256", frames.size()); end
        while (busy === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
            if (prev_sent == 8'd255 && sent_count == 8'd0) wrapped = 1;
            prev_sent = sent_count;
        end
        if (frames.size() == 256) begin
            assert_cnt++; if (cyc - fend[255] !== CLK_DIV + GAP_CYC) begin fail_cnt++; $display("FAIL wrap_busy_end: got %0d cycles expected %0d", cyc - fend[255], CLK_DIV + GAP_CYC); end
            for (int i = 0; i < 256; i++) if (frames[i] !== model_frame(exp_q[i])) bad++;
            for (int i = 1; i < 256; i++) if (fstart[i] - fstart[i-1] != PERIOD) bad_period++;
            assert_cnt++; if (bad !== 0) begin fail_cnt++; $display("FAIL wrap_frames: got %0d bad frames expected 0", bad); end
            assert_cnt++; if (bad_period !== 0) begin fail_cnt++; $display("FAIL wrap_period: got %0d off-period frames expected 0", bad_period); end
        end
        assert_cnt++; if (wrapped !== 1'b1) begin fail_cnt++; $display("FAIL wrap_seen: got %b expected 1", wrapped); end
        assert_cnt++; if (sent_count !== 8'd0) begin fail_cnt++; $display("FAIL wrap_sent: got %0d expected 0", sent_count); end
        assert_cnt++; if (busy_low !== 0) begin fail_cnt++; $display("FAIL wrap_busy_gap: got %0d low cycles expected 0", busy_low); end
    endtask

    initial begin
        test_reset();
        test_single_1c();
        test_make_break();
        test_parity_edges();
        test_random();
        test_fill_in_gap();
        test_reset_mid_frame();
        test_wrap_256();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
